// File: rtl/mpu_pkg.sv
// mpu_pkg
//   Shared types and helpers for the MPU instruction-memory port logic.
//   owner_t      : who owns the RAM response currently in flight
//   bswap32      : 32-bit byte reversal used on the bridge data path
//   BRIDGE_PAGE_DEFAULT : bridge_addr[31:24] value that selects the instruction RAM
package mpu_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_BRG  = 2'd2
    } owner_t;

    localparam logic [7:0]  BRIDGE_PAGE_DEFAULT = 8'h80;
    localparam int unsigned FAIR_CNT_W          = 4;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/mpu_fair_counter.sv
// mpu_fair_counter
//   Saturating event counter. Counts i_inc pulses up to i_limit, clears on
//   i_clear (clear has priority over increment).
// Ports
//   clk        in   core clock
//   reset_n    in   synchronous, active-low reset
//   i_clear    in   return count to 0
//   i_inc      in   count one event
//   i_limit    in   saturation value
//   o_at_limit out  count has reached i_limit
module mpu_fair_counter
    import mpu_pkg::*;
#(
    parameter int unsigned CNT_W = FAIR_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_at_limit
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count < i_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = (r_count >= i_limit);

endmodule

// File: rtl/mpu_imem_port_arbiter.sv
// mpu_imem_port_arbiter
//   Shares port B of the MPU instruction BRAM between the iBus fetch and the
//   APF bridge, one access slot per clk. Bridge wins by default; a fairness
//   counter hands the slot to a waiting fetch after BURST_MAX bridge grants.
//   A one-deep tag routes the 1-cycle-latency RAM response back to its owner.
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   i_cpu_hold                   MPU held in reset, fetch never granted
//   i_little_endian              0: byte-swap bridge data both directions
//   i_ibus_cmd_*, o_ibus_cmd_ready   fetch request / combinational grant
//   o_ibus_rsp_*                 instruction response
//   i_br_req_*, o_br_req_ready   bridge request / combinational grant
//   o_br_rsp_*                   bridge read response
//   o_ram_*, i_ram_q             RAM port B (registered read data)
//   o_busy                       slot or response in flight
module mpu_imem_port_arbiter
    import mpu_pkg::*;
#(
    parameter logic [7:0]  BRIDGE_PAGE = BRIDGE_PAGE_DEFAULT,
    parameter int unsigned WADDR_W     = 22,
    parameter int unsigned BURST_MAX   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_cpu_hold,
    input  logic               i_little_endian,
    input  logic               i_ibus_cmd_valid,
    input  logic [31:0]        i_ibus_cmd_pc,
    output logic               o_ibus_cmd_ready,
    output logic               o_ibus_rsp_valid,
    output logic [31:0]        o_ibus_rsp_inst,
    input  logic               i_br_req_valid,
    input  logic               i_br_req_we,
    input  logic [31:0]        i_br_req_addr,
    input  logic [31:0]        i_br_req_wdata,
    output logic               o_br_req_ready,
    output logic               o_br_rsp_valid,
    output logic [31:0]        o_br_rsp_rdata,
    output logic [WADDR_W-1:0] o_ram_addr,
    output logic               o_ram_rden,
    output logic               o_ram_wren,
    output logic [31:0]        o_ram_wdata,
    input  logic [31:0]        i_ram_q,
    output logic               o_busy
);

    localparam logic [FAIR_CNT_W-1:0] FAIR_LIMIT = FAIR_CNT_W'(BURST_MAX);

    owner_t r_tag;
    logic   r_rsp_zero;     // bridge response is for an off-page read: return 0

    owner_t w_tag_d;
    logic   w_rsp_zero_d;
    logic   w_fetch_pend;
    logic   w_fair_at_limit;
    logic   w_cpu_grant;
    logic   w_brg_grant;
    logic   w_on_page;
    logic   w_unused_addr_bits;

    assign w_unused_addr_bits = ^{i_ibus_cmd_pc, i_br_req_addr};

    // Grants are forced off during reset so no RAM access can happen.
    always_comb begin
        w_fetch_pend = i_ibus_cmd_valid & ~i_cpu_hold;
        w_brg_grant  = reset_n & i_br_req_valid & ~(w_fetch_pend & w_fair_at_limit);
        w_cpu_grant  = reset_n & w_fetch_pend & ~w_brg_grant;
        w_on_page    = (i_br_req_addr[31:24] == BRIDGE_PAGE);
    end

    mpu_fair_counter #(
        .CNT_W      (FAIR_CNT_W)
    ) u_fair_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (~w_fetch_pend | w_cpu_grant),
        .i_inc      (w_brg_grant & w_fetch_pend),
        .i_limit    (FAIR_LIMIT),
        .o_at_limit (w_fair_at_limit)
    );

    // Slot decode: RAM port controls and the tag for next cycle's response.
    always_comb begin
        o_ibus_cmd_ready = w_cpu_grant;
        o_br_req_ready   = w_brg_grant;
        o_ram_addr       = '0;
        o_ram_rden       = 1'b0;
        o_ram_wren       = 1'b0;
        o_ram_wdata      = '0;
        w_tag_d          = OWN_NONE;
        w_rsp_zero_d     = 1'b0;

        if (w_cpu_grant) begin
            o_ram_addr = i_ibus_cmd_pc[WADDR_W+1:2];
            o_ram_rden = 1'b1;
            w_tag_d    = OWN_CPU;
        end else if (w_brg_grant) begin
            if (w_on_page) begin
                o_ram_addr = i_br_req_addr[WADDR_W+1:2];
                if (i_br_req_we) begin
                    o_ram_wren  = 1'b1;
                    o_ram_wdata = i_little_endian ? i_br_req_wdata : bswap32(i_br_req_wdata);
                end else begin
                    o_ram_rden = 1'b1;
                    w_tag_d    = OWN_BRG;
                end
            end else if (!i_br_req_we) begin
                // Off-page read still owes a (zero) response; off-page write is dropped.
                w_tag_d      = OWN_BRG;
                w_rsp_zero_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag      <= OWN_NONE;
            r_rsp_zero <= 1'b0;
        end else begin
            r_tag      <= w_tag_d;
            r_rsp_zero <= w_rsp_zero_d;
        end
    end

    // Response mux; gated by reset_n so a response in flight at reset is discarded.
    always_comb begin
        o_ibus_rsp_valid = reset_n & (r_tag == OWN_CPU);
        o_br_rsp_valid   = reset_n & (r_tag == OWN_BRG);
        o_ibus_rsp_inst  = o_ibus_rsp_valid ? i_ram_q : 32'h0;
        o_br_rsp_rdata   = 32'h0;
        if (o_br_rsp_valid && !r_rsp_zero) begin
            o_br_rsp_rdata = i_little_endian ? i_ram_q : bswap32(i_ram_q);
        end
        o_busy = reset_n & (w_cpu_grant | w_brg_grant | (r_tag != OWN_NONE));
    end

endmodule
